touch_i2c_responder: RTL and testbench
======================================

TOUCH_I2C_RESPONDER -- requirements
Module: touch_i2c_responder

Interface
REQ-001 Parameter DEV_ADDR, default 7'h14, SHALL be the 7-bit I2C target address this block answers.
REQ-002 sys_clk  in  1  single clock, at least 20x the SCL rate; all logic SHALL run on it.
REQ-003 sys_rst  in  1  synchronous, active-high reset.
REQ-004 scl_i  in  1  asynchronous I2C clock from the bus.
REQ-005 sda_i  in  1  asynchronous I2C data from the bus.
REQ-006 sda_oe  out  1  when 1, the pad SHALL pull SDA low; when 0, SDA is released.
REQ-007 pt_valid  in  1  one-cycle strobe that loads a new touch point.
REQ-008 pt_x  in  16  X coordinate, sampled when pt_valid=1.
REQ-009 pt_y  in  16  Y coordinate, sampled when pt_valid=1.
REQ-010 touch_irq  out  1  high while the status ready bit is set.
REQ-011 busy  out  1  high from an accepted START until the next STOP.

Function
REQ-012 scl_i and sda_i SHALL each pass a 2-flop synchronizer plus one history flop; all edges are detected on the synchronized copies.
REQ-013 START is SDA falling while SCL is high; STOP is SDA rising while SCL is high. Both SHALL be recognised in any state.
REQ-014 FSM states: IDLE, DEV, DEV_ACK, RA_HI, RA_HI_ACK, RA_LO, RA_LO_ACK, WDATA, WACK, RDATA, RACK.
- START from any state -> DEV.
- STOP from any state -> IDLE.
REQ-015 Bits SHALL be sampled on the SCL rising edge, MSB first; sda_oe SHALL change only on the SCL falling edge.
REQ-016 DEV handling, after the 8th bit:
- address match -> DEV_ACK, driving ACK (sda_oe=1) for one SCL period;
- mismatch -> IDLE with sda_oe=0.
REQ-017 After DEV_ACK:
- R/W=0 -> RA_HI;
- R/W=1 -> RDATA, with the byte at the register pointer loaded into the shift register.
REQ-018 The register address SHALL be 16 bits, high byte first, and each address byte is ACKed. After RA_LO_ACK the FSM enters WDATA.
REQ-019 Each written byte SHALL be ACKed, and the pointer SHALL then increment modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-020 In RDATA the target SHALL drive the shift-register bits. In RACK it SHALL release SDA and sample the master's ACK/NACK:
- ACK -> pointer+1, load the next byte, return to RDATA;
- NACK -> IDLE, waiting for STOP.
REQ-021 A repeated START SHALL keep the pointer, so a write of the address followed by Sr plus a read returns data from that address.
REQ-022 Register map, read view; all other addresses read 0x00:
- 0x8140..0x8143 = 0x39, 0x31, 0x31, 0x00;
- 0x814E = {ready, 3'b0, count[3:0]}, where count is 0 or 1;
- 0x8150 = X[7:0], 0x8151 = X[15:8], 0x8152 = Y[7:0], 0x8153 = Y[15:8].
REQ-023 Write behaviour:
- any byte written to 0x814E SHALL clear ready and count;
- writes to other addresses are ACKed and discarded.
REQ-024 pt_valid while busy=0 SHALL load X/Y and set ready=1, count=1 on the next cycle.
REQ-025 pt_valid while busy=1 SHALL capture the point into a pending buffer, applied on the cycle after STOP. Coordinates SHALL never change inside a transaction.
REQ-026 A later pt_valid during the same transaction SHALL overwrite the pending point (last one wins).
REQ-027 If pending is applied on the same STOP that ended a write to 0x814E, the clear SHALL take effect first, then pending sets ready=1.
REQ-028 touch_irq SHALL equal ready, registered with no further delay.

Reset
REQ-029 While sys_rst=1 the following SHALL all be zero, and the FSM SHALL be in IDLE:
- sda_oe, busy, touch_irq;
- ready, count, X, Y, pointer, pending.
REQ-030 Reset asserted mid-transaction SHALL release SDA in the same cycle it is sampled. After reset the block SHALL ignore the bus until the next START.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state enumeration;
- register address constants 0x8140, 0x814E, 0x8150..0x8153;
- the ID byte constants.
REQ-032 One sub-module, i2c_bus_sync, SHALL contain the synchronizers and the START/STOP/SCL-edge detectors. The FSM and registers form the top.

Verification
REQ-033 Read ID: write 0x28, 0x81, 0x40, Sr, 0x29, read 4 bytes, NACK the last -> 0x39, 0x31, 0x31, 0x00 with ACK on all 3 write bytes.
REQ-034 Point read: pt_valid with X=0x031F, Y=0x01DF, then read 5 bytes from 0x814E -> 0x81, 0x00, 0x1F, 0x03, 0xDF; touch_irq=1.
REQ-035 Clear status: write 0x00 to 0x814E -> touch_irq falls after the data ACK. A re-read returns 0x00.
REQ-036 Pending point: pt_valid X=0x0010 during a read of 0x8150, then another pt_valid X=0x0020 before STOP -> the read returns the old X; after STOP a read returns 0x20.
REQ-037 Wrong address: address 0x2A (7'h15) -> no ACK, sda_oe stays 0, and no register changes.
REQ-038 Reset mid-read: assert sys_rst during RDATA bit 3 -> sda_oe=0 the next cycle, all outputs 0, and the next full transaction behaves normally.

Source files
------------

// File: rtl/touch_i2c_responder_pkg.sv
// rtl/touch_i2c_responder_pkg.sv - shared FSM states, register map constants and read mux
package touch_i2c_responder_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV,
      ST_DEV_ACK,
      ST_RA_HI,
      ST_RA_HI_ACK,
      ST_RA_LO,
      ST_RA_LO_ACK,
      ST_WDATA,
      ST_WACK,
      ST_RDATA,
      ST_RACK
   } state_e;

   localparam logic [15:0] ADDR_ID_BASE = 16'h8140;
   localparam logic [15:0] ADDR_STATUS  = 16'h814E;
   localparam logic [15:0] ADDR_X_LO    = 16'h8150;
   localparam logic [15:0] ADDR_X_HI    = 16'h8151;
   localparam logic [15:0] ADDR_Y_LO    = 16'h8152;
   localparam logic [15:0] ADDR_Y_HI    = 16'h8153;

   localparam logic [7:0] ID_BYTE0 = 8'h39;
   localparam logic [7:0] ID_BYTE1 = 8'h31;
   localparam logic [7:0] ID_BYTE2 = 8'h31;
   localparam logic [7:0] ID_BYTE3 = 8'h00;

   // Read view of the register map; unmapped addresses return zero.
   function automatic logic [7:0] reg_read(input logic [15:0] addr, input logic ready,
                                           input logic [3:0] count, input logic [15:0] x,
                                           input logic [15:0] y);
      logic [7:0] rd;
      rd = 8'h00;
      case (addr)
         ADDR_ID_BASE:          rd = ID_BYTE0;
         ADDR_ID_BASE + 16'd1:  rd = ID_BYTE1;
         ADDR_ID_BASE + 16'd2:  rd = ID_BYTE2;
         ADDR_ID_BASE + 16'd3:  rd = ID_BYTE3;
         ADDR_STATUS:           rd = {ready, 3'b000, count};
         ADDR_X_LO:             rd = x[7:0];
         ADDR_X_HI:             rd = x[15:8];
         ADDR_Y_LO:             rd = y[7:0];
         ADDR_Y_HI:             rd = y[15:8];
         default:               rd = 8'h00;
      endcase
      return rd;
   endfunction

endpackage

// File: rtl/touch_i2c_responder_i2c_bus_sync.sv
// rtl/touch_i2c_responder_i2c_bus_sync.sv - SCL/SDA synchronizers with START/STOP and SCL edge detect
module i2c_bus_sync (
   input  logic clk_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);
   // [1:0] are the synchronizer stages, [2] is the history flop; free-running so no reset glitch on the bus view
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   always_ff @(posedge clk_i) begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
   end

   assign sda_o      = sda_q[1];
   assign scl_rise_o = scl_q[1] & ~scl_q[2];
   assign scl_fall_o = ~scl_q[1] & scl_q[2];
   assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/touch_i2c_responder.sv
// rtl/touch_i2c_responder.sv - I2C touch target: byte FSM, register pointer, status and point registers
module touch_i2c_responder
   import touch_i2c_responder_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h14
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   input  logic        pt_valid,
   input  logic [15:0] pt_x,
   input  logic [15:0] pt_y,
   output logic        touch_irq,
   output logic        busy
);
   logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

   i2c_bus_sync u_sync (
      .clk_i      (sys_clk),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (bus_start),
      .stop_o     (bus_stop)
   );

   state_e      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        byte_done_q, byte_done_d;
   logic [7:0]  shift_q, shift_d;
   logic        rw_q, rw_d;
   logic [15:0] ptr_q, ptr_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic [3:0]  count_q, count_d;
   logic [15:0] x_q, x_d, y_q, y_d;
   logic        pend_q, pend_d;
   logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic        status_clr;
   logic        last_bit;
   logic [7:0]  rd_byte;

   assign last_bit = (bit_cnt_q == 3'd7);
   assign rd_byte  = reg_read(ptr_q, ready_q, count_q, x_q, y_q);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus_start) begin
         state_d = ST_DEV;
      end else if (bus_stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_DEV: begin
               if (scl_rise && last_bit && (shift_q[6:0] != DEV_ADDR)) state_d = ST_IDLE;
               else if (scl_fall && byte_done_q)                       state_d = ST_DEV_ACK;
            end
            ST_DEV_ACK:   if (scl_fall) state_d = rw_q ? ST_RDATA : ST_RA_HI;
            ST_RA_HI:     if (scl_fall && byte_done_q) state_d = ST_RA_HI_ACK;
            ST_RA_HI_ACK: if (scl_fall) state_d = ST_RA_LO;
            ST_RA_LO:     if (scl_fall && byte_done_q) state_d = ST_RA_LO_ACK;
            ST_RA_LO_ACK: if (scl_fall) state_d = ST_WDATA;
            ST_WDATA:     if (scl_fall && byte_done_q) state_d = ST_WACK;
            ST_WACK:      if (scl_fall) state_d = ST_WDATA;
            ST_RDATA:     if (scl_fall && byte_done_q) state_d = ST_RACK;
            ST_RACK: begin
               if (scl_rise && sda_s) state_d = ST_IDLE;
               else if (scl_fall)     state_d = ST_RDATA;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      byte_done_d = byte_done_q;
      rw_d        = rw_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      ready_d     = ready_q;
      count_d     = count_q;
      x_d         = x_q;
      y_d         = y_q;
      pend_d      = pend_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      status_clr  = 1'b0;

      if (bus_start || bus_stop) begin
         bit_cnt_d   = 3'd0;
         byte_done_d = 1'b0;
         sda_oe_d    = 1'b0;
         busy_d      = bus_start;
      end else begin
         case (state_q)
            ST_DEV, ST_RA_HI, ST_RA_LO, ST_WDATA: begin
               if (scl_rise) begin
                  shift_d     = {shift_q[6:0], sda_s};
                  bit_cnt_d   = bit_cnt_q + 3'd1;
                  byte_done_d = last_bit;
                  if (last_bit && state_q == ST_DEV)   rw_d        = sda_s;
                  if (last_bit && state_q == ST_RA_HI) ptr_d[15:8] = {shift_q[6:0], sda_s};
                  if (last_bit && state_q == ST_RA_LO) ptr_d[7:0]  = {shift_q[6:0], sda_s};
               end else if (scl_fall && byte_done_q) begin
                  byte_done_d = 1'b0;
                  sda_oe_d    = 1'b1;
               end
            end
            ST_DEV_ACK: if (scl_fall) begin
               sda_oe_d = rw_q & ~rd_byte[7];
               if (rw_q) shift_d = rd_byte;
            end
            ST_RA_HI_ACK, ST_RA_LO_ACK: if (scl_fall) sda_oe_d = 1'b0;
            ST_WACK: if (scl_fall) begin
               sda_oe_d   = 1'b0;
               ptr_d      = ptr_q + 16'd1;
               status_clr = (ptr_q == ADDR_STATUS);
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d   = bit_cnt_q + 3'd1;
                  byte_done_d = last_bit;
               end else if (scl_fall && byte_done_q) begin
                  byte_done_d = 1'b0;
                  sda_oe_d    = 1'b0;
               end else if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
            ST_RACK: begin
               // pointer advances on the master's ACK so the reload on the fall reads the next byte
               if (scl_rise && !sda_s) begin
                  ptr_d = ptr_q + 16'd1;
               end else if (scl_fall) begin
                  shift_d  = rd_byte;
                  sda_oe_d = ~rd_byte[7];
               end
            end
            default: ;
         endcase
      end

      if (status_clr) begin
         ready_d = 1'b0;
         count_d = 4'd0;
      end
      // pending point lands only once the bus is idle, after any clear from the same transaction
      if (!busy_q && pend_q) begin
         x_d     = pend_x_q;
         y_d     = pend_y_q;
         ready_d = 1'b1;
         count_d = 4'd1;
         pend_d  = 1'b0;
      end
      if (pt_valid && busy_q) begin
         pend_d   = 1'b1;
         pend_x_d = pt_x;
         pend_y_d = pt_y;
      end else if (pt_valid) begin
         x_d     = pt_x;
         y_d     = pt_y;
         ready_d = 1'b1;
         count_d = 4'd1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shift_q     <= 8'h00;
         bit_cnt_q   <= 3'd0;
         byte_done_q <= 1'b0;
         rw_q        <= 1'b0;
         ptr_q       <= 16'h0000;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
         count_q     <= 4'd0;
         x_q         <= 16'h0000;
         y_q         <= 16'h0000;
         pend_q      <= 1'b0;
         pend_x_q    <= 16'h0000;
         pend_y_q    <= 16'h0000;
      end else begin
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_done_q <= byte_done_d;
         rw_q        <= rw_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
         count_q     <= count_d;
         x_q         <= x_d;
         y_q         <= y_d;
         pend_q      <= pend_d;
         pend_x_q    <= pend_x_d;
         pend_y_q    <= pend_y_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign touch_irq = ready_q;

endmodule

// File: tb/tb_touch_i2c_responder.sv
// tb/tb_touch_i2c_responder.sv - scoreboard bench driving an I2C master against touch_i2c_responder
module tb_touch_i2c_responder;
   localparam int Q = 80;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        pt_valid = 1'b0;
   logic [15:0] pt_x = 16'h0;
   logic [15:0] pt_y = 16'h0;
   logic        sda_oe, touch_irq, busy;
   logic        sda_line;

   assign sda_line = sda_m & ~sda_oe;

   touch_i2c_responder #(.DEV_ADDR(7'h14)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .scl_i     (scl_m),
      .sda_i     (sda_line),
      .sda_oe    (sda_oe),
      .pt_valid  (pt_valid),
      .pt_x      (pt_x),
      .pt_y      (pt_y),
      .touch_irq (touch_irq),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;

   int oe_cnt = 0;
   always @(posedge sys_clk) if (sda_oe) oe_cnt++;

   typedef struct {
      string       name;
      logic [15:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] act_q[$];
   int          checks = 0;
   int          errors = 0;

   task automatic expect_v(input string name, input logic [15:0] v);
      exp_t e;
      e.name = name;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic [15:0] v);
      act_q.push_back(v);
   endtask

   initial begin : monitor
      exp_t        e;
      logic [15:0] a;
      forever begin
         @(negedge sys_clk);
         while (act_q.size() > 0) begin
            a = act_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output actual=%h required=none", a);
            end else begin
               e = exp_q.pop_front();
               if (a !== e.val) begin
                  errors++;
                  $display("FAIL %s actual=%h required=%h", e.name, a, e.val);
               end
            end
         end
      end
   end

   task automatic bit_out(input logic b);
      sda_m = b; #(Q);
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #(Q);
   endtask

   task automatic bit_in(output logic b);
      sda_m = 1'b1; #(Q);
      scl_m = 1'b1; #(Q);
      b = sda_line; #(Q);
      scl_m = 1'b0; #(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #(Q);
      scl_m = 1'b1; #(Q);
      sda_m = 1'b0; #(Q);
      scl_m = 1'b0; #(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #(Q);
      scl_m = 1'b1; #(Q);
      sda_m = 1'b1; #(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string name);
      logic a;
      expect_v(name, {15'd0, exp_ack});
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(a);
      observe({15'd0, ~a});
   endtask

   task automatic rd_byte(input logic [7:0] exp_b, input logic last, input string name);
      logic [7:0] d;
      logic       b;
      expect_v(name, {8'd0, exp_b});
      for (int i = 7; i >= 0; i--) begin
         bit_in(b);
         d[i] = b;
      end
      observe({8'd0, d});
      bit_out(last);
      sda_m = 1'b1;
   endtask

   task automatic set_ptr(input logic [15:0] addr);
      i2c_start();
      wr_byte(8'h28, 1'b1, "ack_dev_w");
      wr_byte(addr[15:8], 1'b1, "ack_ra_hi");
      wr_byte(addr[7:0], 1'b1, "ack_ra_lo");
   endtask

   task automatic begin_read(input logic [15:0] addr);
      set_ptr(addr);
      i2c_start();
      wr_byte(8'h29, 1'b1, "ack_dev_r");
   endtask

   task automatic write_reg(input logic [15:0] addr, input logic [7:0] d);
      set_ptr(addr);
      wr_byte(d, 1'b1, "ack_wdata");
      i2c_stop();
   endtask

   task automatic pulse_pt(input logic [15:0] x, input logic [15:0] y);
      @(negedge sys_clk);
      pt_valid = 1'b1; pt_x = x; pt_y = y;
      @(negedge sys_clk);
      pt_valid = 1'b0;
   endtask

   task automatic check_sig(input string name, input logic exp_v, input logic act_v);
      expect_v(name, {15'd0, exp_v});
      observe({15'd0, act_v});
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic b;
      int   oe_before;

      repeat (3) @(negedge sys_clk);
      check_sig("rst_sda_oe", 1'b0, sda_oe);
      check_sig("rst_busy", 1'b0, busy);
      check_sig("rst_irq", 1'b0, touch_irq);
      sys_rst = 1'b0;
      repeat (5) @(negedge sys_clk);

      // status, X and pointer start cleared
      begin_read(16'h814E);
      rd_byte(8'h00, 1'b0, "rst_status");
      rd_byte(8'h00, 1'b0, "rst_814f");
      rd_byte(8'h00, 1'b1, "rst_x_lo");
      i2c_stop();

      // ID read with repeated start
      begin_read(16'h8140);
      rd_byte(8'h39, 1'b0, "id0");
      rd_byte(8'h31, 1'b0, "id1");
      rd_byte(8'h31, 1'b0, "id2");
      rd_byte(8'h00, 1'b1, "id3");
      i2c_stop();

      // point load while idle
      pulse_pt(16'h031F, 16'h01DF);
      @(negedge sys_clk);
      check_sig("irq_after_pt", 1'b1, touch_irq);
      begin_read(16'h814E);
      check_sig("busy_in_txn", 1'b1, busy);
      rd_byte(8'h81, 1'b0, "pt_status");
      rd_byte(8'h00, 1'b0, "pt_814f");
      rd_byte(8'h1F, 1'b0, "pt_x_lo");
      rd_byte(8'h03, 1'b0, "pt_x_hi");
      rd_byte(8'hDF, 1'b1, "pt_y_lo");
      i2c_stop();
      @(negedge sys_clk);
      check_sig("busy_after_stop", 1'b0, busy);

      // clear status
      set_ptr(16'h814E);
      check_sig("irq_before_clr", 1'b1, touch_irq);
      wr_byte(8'h00, 1'b1, "ack_clr");
      @(negedge sys_clk);
      check_sig("irq_after_clr", 1'b0, touch_irq);
      i2c_stop();
      begin_read(16'h814E);
      rd_byte(8'h00, 1'b1, "status_cleared");
      i2c_stop();

      // pending point: last one wins, applied after STOP
      begin_read(16'h8150);
      pulse_pt(16'h0010, 16'h0011);
      rd_byte(8'h1F, 1'b0, "pend_old_x_lo");
      pulse_pt(16'h0020, 16'h0030);
      rd_byte(8'h03, 1'b1, "pend_old_x_hi");
      check_sig("irq_pend_held", 1'b0, touch_irq);
      i2c_stop();
      repeat (3) @(negedge sys_clk);
      check_sig("irq_pend_applied", 1'b1, touch_irq);
      begin_read(16'h8150);
      rd_byte(8'h20, 1'b0, "pend_x_lo");
      rd_byte(8'h00, 1'b0, "pend_x_hi");
      rd_byte(8'h30, 1'b1, "pend_y_lo");
      i2c_stop();

      // clear and pending on the same STOP: pending wins
      set_ptr(16'h814E);
      pulse_pt(16'h0123, 16'h0456);
      wr_byte(8'h00, 1'b1, "ack_clr2");
      i2c_stop();
      repeat (3) @(negedge sys_clk);
      check_sig("irq_clr_then_pend", 1'b1, touch_irq);
      begin_read(16'h814E);
      rd_byte(8'h81, 1'b0, "cp_status");
      rd_byte(8'h00, 1'b0, "cp_814f");
      rd_byte(8'h23, 1'b0, "cp_x_lo");
      rd_byte(8'h01, 1'b1, "cp_x_hi");
      i2c_stop();

      // wrong device address: no ACK, no register change
      oe_before = oe_cnt;
      i2c_start();
      wr_byte(8'h2A, 1'b0, "nack_dev");
      wr_byte(8'h81, 1'b0, "nack_b1");
      wr_byte(8'h4E, 1'b0, "nack_b2");
      wr_byte(8'h00, 1'b0, "nack_b3");
      i2c_stop();
      expect_v("wrong_addr_oe_cycles", 16'd0);
      observe(16'(oe_cnt - oe_before));
      check_sig("wrong_addr_irq", 1'b1, touch_irq);
      begin_read(16'h814E);
      rd_byte(8'h81, 1'b1, "wrong_addr_status");
      i2c_stop();

      // write increments pointer; Sr read continues at the next address
      set_ptr(16'h813F);
      wr_byte(8'h55, 1'b1, "ack_inc");
      i2c_start();
      wr_byte(8'h29, 1'b1, "ack_inc_r");
      rd_byte(8'h39, 1'b1, "inc_read");
      i2c_stop();

      // reset while driving bit 3 of a read byte
      begin_read(16'h8143);
      for (int i = 0; i < 4; i++) bit_in(b);
      @(negedge sys_clk);
      check_sig("oe_bit3_driven", 1'b1, sda_oe);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check_sig("midrst_sda_oe", 1'b0, sda_oe);
      check_sig("midrst_busy", 1'b0, busy);
      check_sig("midrst_irq", 1'b0, touch_irq);
      sys_rst = 1'b0;
      oe_before = oe_cnt;
      for (int i = 0; i < 4; i++) bit_in(b);
      bit_out(1'b1);
      i2c_stop();
      expect_v("postrst_oe_cycles", 16'd0);
      observe(16'(oe_cnt - oe_before));
      begin_read(16'h8140);
      rd_byte(8'h39, 1'b0, "postrst_id0");
      rd_byte(8'h31, 1'b1, "postrst_id1");
      i2c_stop();
      begin_read(16'h814E);
      rd_byte(8'h00, 1'b0, "postrst_status");
      rd_byte(8'h00, 1'b0, "postrst_814f");
      rd_byte(8'h00, 1'b1, "postrst_x_lo");
      i2c_stop();

      repeat (20) @(negedge sys_clk);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s actual=missing required=%h", e.name, e.val);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
